fb_ram_arbiter: RTL and testbench

FB_RAM_ARBITER -- requirements
Module: fb_ram_arbiter

---
 rtl/fb_ram_arbiter_pkg.sv | 22 ++
 rtl/fb_starve_counter.sv | 40 ++++
 rtl/fb_ram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_fb_ram_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_ram_arbiter_pkg.sv
// Shared definitions for the frame-buffer RAM arbiter.
// Holds the arbiter state encoding, the default address/data widths, the panel
// geometry and the position of the bank-select bit in the host address.
package fb_ram_arbiter_pkg;

    localparam int unsigned FB_ADDR_W       = 12;  // word address width within one page
    localparam int unsigned FB_DATA_W       = 12;  // RGB444 pixel word per bank

    localparam int unsigned FB_PANEL_W      = 96;  // pixels per row
    localparam int unsigned FB_PANEL_ROWS   = 24;  // rows per half-panel scan
    localparam int unsigned FB_BIT_PLANES   = 4;   // BCM bit-planes per colour

    // Host address MSB (just above the word address) selects bank 2 when set.
    localparam int unsigned FB_BANK_SEL_BIT = FB_ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DISP = 2'd1,
        ST_HOST = 2'd2
    } arb_state_t;

endpackage

// File: rtl/fb_starve_counter.sv
// Saturating starvation counter for the frame-buffer arbiter.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_inc        : count one display grant made while a host write waits
//   i_clr        : clear (host granted or no host write pending); wins over i_inc
//   o_sat        : counter has reached MAX; it holds there until cleared
module fb_starve_counter #(
    parameter int unsigned MAX = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    localparam int unsigned CNT_W = $clog2(MAX + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != CNT_W'(MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_sat = (cnt_q == CNT_W'(MAX));

endmodule

// File: rtl/fb_ram_arbiter.sv
// Frame-buffer RAM arbiter: shares a dual-bank, double-paged pixel RAM between
// the LED panel display reader and a host writer, and handles page swaps.
// Ports:
//   i_clk, i_rst                      : clock, synchronous active-high reset
//   i_disp_rd_stb, i_disp_addr        : display read request (level) and word address
//   o_disp_b1_data, o_disp_b2_data    : upper / lower half-panel read data
//   o_disp_valid                      : read data valid (one cycle after the read grant)
//   i_host_req/addr/data, o_host_ack  : host write request (MSB of addr = bank 2), ack pulse
//   i_frame_end, i_swap_req           : frame wrap pulse, page swap request pulse
//   o_swap_done, o_disp_page          : swap taken effect pulse, displayed page
//   o_ram_addr, o_ram_we_b1/b2        : RAM address {page, word} and bank write enables
//   o_ram_wdata                       : RAM write data
//   i_ram_b1_rdata, i_ram_b2_rdata    : RAM read data
// The grant is registered: RAM address/enables/ack are flops loaded with the
// decision, so the RAM sees the grant in the cycle the state register holds it.
module fb_ram_arbiter
    import fb_ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = FB_ADDR_W,
    parameter int unsigned DATA_W     = FB_DATA_W,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_disp_rd_stb,
    input  logic [ADDR_W-1:0] i_disp_addr,
    output logic [DATA_W-1:0] o_disp_b1_data,
    output logic [DATA_W-1:0] o_disp_b2_data,
    output logic              o_disp_valid,
    input  logic              i_host_req,
    input  logic [ADDR_W:0]   i_host_addr,
    input  logic [DATA_W-1:0] i_host_data,
    output logic              o_host_ack,
    input  logic              i_frame_end,
    input  logic              i_swap_req,
    output logic              o_swap_done,
    output logic              o_disp_page,
    output logic [ADDR_W:0]   o_ram_addr,
    output logic              o_ram_we_b1,
    output logic              o_ram_we_b2,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_b1_rdata,
    input  logic [DATA_W-1:0] i_ram_b2_rdata
);

    // Bank-select bit tracks the word address width when ADDR_W is overridden.
    localparam int unsigned BANK_SEL = ADDR_W + (FB_BANK_SEL_BIT - FB_ADDR_W);

    arb_state_t        state_q, state_d;
    logic [ADDR_W:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              we_b1_q, we_b1_d;
    logic              we_b2_q, we_b2_d;
    logic              host_ack_q, host_ack_d;
    logic              disp_valid_q, disp_valid_d;
    logic [DATA_W-1:0] disp_b1_q, disp_b1_d;
    logic [DATA_W-1:0] disp_b2_q, disp_b2_d;
    logic              page_q, page_d;
    logic              swap_pend_q, swap_pend_d;
    logic              swap_done_q, swap_done_d;

    logic              host_pend;
    logic              starve_sat;
    logic              starve_inc;
    logic              starve_clr;

    // The request is still high during its own HOST cycle (the host drops it
    // after seeing the ack), so it is masked there to avoid a double write.
    assign host_pend  = i_host_req && (state_q != ST_HOST);
    assign starve_inc = (state_d == ST_DISP) && host_pend;
    assign starve_clr = !host_pend || (state_d == ST_HOST);

    fb_starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (starve_inc),
        .i_clr (starve_clr),
        .o_sat (starve_sat)
    );

    always_comb begin
        // Page swap: a request coinciding with the frame end is honoured on it;
        // repeat requests while pending collapse into the single flag.
        swap_pend_d = swap_pend_q | i_swap_req;
        page_d      = page_q;
        swap_done_d = 1'b0;
        if (i_frame_end && swap_pend_d) begin
            page_d      = ~page_q;
            swap_done_d = 1'b1;
            swap_pend_d = 1'b0;
        end

        state_d = ST_IDLE;
        if (host_pend && (!i_disp_rd_stb || starve_sat)) begin
            state_d = ST_HOST;
        end else if (i_disp_rd_stb) begin
            state_d = ST_DISP;
        end

        // Grants use page_d so a grant made on the toggling edge already sees
        // the new page, while a read registered earlier completes on the old one.
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        we_b1_d     = 1'b0;
        we_b2_d     = 1'b0;
        host_ack_d  = 1'b0;
        case (state_d)
            ST_DISP: begin
                ram_addr_d = {page_d, i_disp_addr};
            end
            ST_HOST: begin
                ram_addr_d  = {~page_d, i_host_addr[ADDR_W-1:0]};
                ram_wdata_d = i_host_data;
                we_b1_d     = ~i_host_addr[BANK_SEL];
                we_b2_d     = i_host_addr[BANK_SEL];
                host_ack_d  = 1'b1;
            end
            default: ;
        endcase

        disp_valid_d = (state_q == ST_DISP);
        disp_b1_d    = disp_b1_q;
        disp_b2_d    = disp_b2_q;
        if (state_q == ST_DISP) begin
            disp_b1_d = i_ram_b1_rdata;
            disp_b2_d = i_ram_b2_rdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            we_b1_q      <= 1'b0;
            we_b2_q      <= 1'b0;
            host_ack_q   <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_b1_q    <= '0;
            disp_b2_q    <= '0;
            page_q       <= 1'b0;
            swap_pend_q  <= 1'b0;
            swap_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            we_b1_q      <= we_b1_d;
            we_b2_q      <= we_b2_d;
            host_ack_q   <= host_ack_d;
            disp_valid_q <= disp_valid_d;
            disp_b1_q    <= disp_b1_d;
            disp_b2_q    <= disp_b2_d;
            page_q       <= page_d;
            swap_pend_q  <= swap_pend_d;
            swap_done_q  <= swap_done_d;
        end
    end

    assign o_ram_addr     = ram_addr_q;
    assign o_ram_wdata    = ram_wdata_q;
    assign o_ram_we_b1    = we_b1_q;
    assign o_ram_we_b2    = we_b2_q;
    assign o_host_ack     = host_ack_q;
    assign o_disp_valid   = disp_valid_q;
    assign o_disp_b1_data = disp_b1_q;
    assign o_disp_b2_data = disp_b2_q;
    assign o_disp_page    = page_q;
    assign o_swap_done    = swap_done_q;

endmodule

// File: tb/tb_fb_ram_arbiter.sv
// Self-checking bench for fb_ram_arbiter: directed stimulus pushes expected
// host writes, display reads and swaps into queues; a monitor pops and
// compares whenever the DUT presents an ack, a valid or a swap_done.
module tb_fb_ram_arbiter;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 12;
    localparam int unsigned SM = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_disp_rd_stb;
    logic [AW-1:0] i_disp_addr;
    logic [DW-1:0] o_disp_b1_data, o_disp_b2_data;
    logic          o_disp_valid;
    logic          i_host_req;
    logic [AW:0]   i_host_addr;
    logic [DW-1:0] i_host_data;
    logic          o_host_ack;
    logic          i_frame_end, i_swap_req;
    logic          o_swap_done, o_disp_page;
    logic [AW:0]   o_ram_addr;
    logic          o_ram_we_b1, o_ram_we_b2;
    logic [DW-1:0] o_ram_wdata;
    logic [DW-1:0] i_ram_b1_rdata, i_ram_b2_rdata;

    always #5 clk = ~clk;

    fb_ram_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (SM)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_disp_rd_stb  (i_disp_rd_stb),
        .i_disp_addr    (i_disp_addr),
        .o_disp_b1_data (o_disp_b1_data),
        .o_disp_b2_data (o_disp_b2_data),
        .o_disp_valid   (o_disp_valid),
        .i_host_req     (i_host_req),
        .i_host_addr    (i_host_addr),
        .i_host_data    (i_host_data),
        .o_host_ack     (o_host_ack),
        .i_frame_end    (i_frame_end),
        .i_swap_req     (i_swap_req),
        .o_swap_done    (o_swap_done),
        .o_disp_page    (o_disp_page),
        .o_ram_addr     (o_ram_addr),
        .o_ram_we_b1    (o_ram_we_b1),
        .o_ram_we_b2    (o_ram_we_b2),
        .o_ram_wdata    (o_ram_wdata),
        .i_ram_b1_rdata (i_ram_b1_rdata),
        .i_ram_b2_rdata (i_ram_b2_rdata)
    );

    // RAM model: the arbiter's o_ram_addr register is the RAM address register,
    // so read data follows it one cycle after the grant decision.
    logic [DW-1:0] ram1 [0:8191];
    logic [DW-1:0] ram2 [0:8191];

    function automatic logic [11:0] pat1(input logic pg, input logic [11:0] w);
        return w ^ (pg ? 12'hF00 : 12'h000);
    endfunction

    function automatic logic [11:0] pat2(input logic pg, input logic [11:0] w);
        return w ^ 12'h0FF ^ (pg ? 12'hF00 : 12'h000);
    endfunction

    initial begin
        for (int a = 0; a < 8192; a++) begin
            logic [12:0] ai;
            ai = 13'(a);
            ram1[a] = pat1(ai[12], ai[11:0]);
            ram2[a] = pat2(ai[12], ai[11:0]);
        end
        ram1[13'h0010] = 12'h123;
        ram2[13'h0010] = 12'h456;
        forever begin
            @(posedge clk);
            if (o_ram_we_b1) ram1[o_ram_addr] <= o_ram_wdata;
            if (o_ram_we_b2) ram2[o_ram_addr] <= o_ram_wdata;
        end
    end

    assign i_ram_b1_rdata = ram1[o_ram_addr];
    assign i_ram_b2_rdata = ram2[o_ram_addr];

    typedef struct packed {
        logic [12:0] addr;
        logic        we1;
        logic        we2;
        logic [11:0] wdata;
    } host_exp_t;

    typedef struct packed {
        logic [11:0] b1;
        logic [11:0] b2;
    } disp_exp_t;

    host_exp_t host_q[$];
    disp_exp_t disp_q[$];
    logic      swap_q[$];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (o_host_ack || o_ram_we_b1 || o_ram_we_b2) begin
                check("host_ack_we_align", 32'({o_host_ack, o_ram_we_b1 | o_ram_we_b2}), 32'h3);
                if (host_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL host_unexpected: ack at addr 0x%0h with no write expected", o_ram_addr);
                end else begin
                    host_exp_t he;
                    he = host_q.pop_front();
                    check("host_addr", 32'(o_ram_addr), 32'(he.addr));
                    check("host_we", 32'({o_ram_we_b1, o_ram_we_b2}), 32'({he.we1, he.we2}));
                    check("host_wdata", 32'(o_ram_wdata), 32'(he.wdata));
                end
            end
            if (o_disp_valid) begin
                if (disp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL disp_unexpected: valid with data 0x%0h/0x%0h", o_disp_b1_data, o_disp_b2_data);
                end else begin
                    disp_exp_t de;
                    de = disp_q.pop_front();
                    check("disp_b1", 32'(o_disp_b1_data), 32'(de.b1));
                    check("disp_b2", 32'(o_disp_b2_data), 32'(de.b2));
                end
            end
            if (o_swap_done) begin
                if (swap_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL swap_unexpected: swap_done with page %0d", o_disp_page);
                end else begin
                    logic pe;
                    pe = swap_q.pop_front();
                    check("swap_page", 32'(o_disp_page), 32'(pe));
                end
            end
        end
    end

    task automatic host_write(input logic [12:0] addr, input logic [11:0] data,
                              input logic [12:0] exp_addr, input logic [1:0] exp_we);
        logic got;
        host_q.push_back('{exp_addr, exp_we[1], exp_we[0], data});
        i_host_req  = 1'b1;
        i_host_addr = addr;
        i_host_data = data;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = o_host_ack;
        end
        check("host_ack_timeout", 32'(got), 32'h1);
        i_host_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic disp_read(input logic [11:0] addr, input logic [11:0] b1, input logic [11:0] b2);
        disp_q.push_back('{b1, b2});
        i_disp_rd_stb = 1'b1;
        i_disp_addr   = addr;
        @(negedge clk);
        i_disp_rd_stb = 1'b0;
        check("disp_lat_grant", 32'(o_disp_valid), 32'h0);
        @(negedge clk);
        check("disp_lat_valid", 32'(o_disp_valid), 32'h1);
        @(negedge clk);
    endtask

    task automatic pulse_swap();
        i_swap_req = 1'b1;
        @(negedge clk);
        i_swap_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int unsigned nval;
        int unsigned early;
        logic        got;
        disp_exp_t   de;

        rst = 1'b1;
        i_disp_rd_stb = 1'b0;
        i_disp_addr = '0;
        i_host_req = 1'b0;
        i_host_addr = '0;
        i_host_data = '0;
        i_frame_end = 1'b0;
        i_swap_req = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ctl", 32'({o_disp_valid, o_host_ack, o_swap_done, o_ram_we_b1, o_ram_we_b2, o_disp_page}), 32'h0);
        check("rst_ram_addr", 32'(o_ram_addr), 32'h0);
        check("rst_wdata", 32'(o_ram_wdata), 32'h0);
        check("rst_disp_data", 32'({o_disp_b1_data, o_disp_b2_data}), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Host writes on page 0 land in page 1
        host_write(13'h0005, 12'hABC, 13'h1005, 2'b10);
        host_write(13'h1007, 12'h3C5, 13'h1007, 2'b01);
        check("idle_addr_hold", 32'(o_ram_addr), 32'h1007);
        check("idle_wdata_hold", 32'(o_ram_wdata), 32'h3C5);
        check("idle_we", 32'({o_ram_we_b1, o_ram_we_b2}), 32'h0);

        // Single display read
        disp_read(12'h010, 12'h123, 12'h456);

        // Starvation: display held, host waits exactly SM display grants
        de.b1 = 12'h020;
        de.b2 = 12'h0DF;
        for (int i = 0; i < 10; i++) disp_q.push_back(de);
        host_q.push_back('{13'h1033, 1'b1, 1'b0, 12'h5A5});
        i_disp_rd_stb = 1'b1;
        i_disp_addr   = 12'h020;
        i_host_req    = 1'b1;
        i_host_addr   = 13'h0033;
        i_host_data   = 12'h5A5;
        nval = 0;
        got  = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (o_disp_valid) nval++;
            got = o_host_ack;
        end
        check("starve_ack_seen", 32'(got), 32'h1);
        check("starve_disp_grants", nval, 32'd8);
        i_host_req = 1'b0;
        @(negedge clk);
        check("starve_host_gap", 32'(o_disp_valid), 32'h0);
        @(negedge clk);
        check("starve_disp_resumes", 32'(o_disp_valid), 32'h1);
        i_disp_rd_stb = 1'b0;
        repeat (3) @(negedge clk);

        // Swap request at cycle 10, frame end at cycle 50
        early = 0;
        swap_q.push_back(1'b1);
        for (int cyc = 0; cyc <= 50; cyc++) begin
            i_swap_req  = (cyc == 10);
            i_frame_end = (cyc == 50);
            @(negedge clk);
            if (cyc < 50 && (o_disp_page !== 1'b0 || o_swap_done !== 1'b0)) early++;
        end
        i_swap_req  = 1'b0;
        i_frame_end = 1'b0;
        check("swap_no_early_change", early, 32'd0);
        check("swap_cycle51", 32'({o_disp_page, o_swap_done}), 32'h3);
        @(negedge clk);

        // Coincident request and frame end
        swap_q.push_back(1'b0);
        i_swap_req  = 1'b1;
        i_frame_end = 1'b1;
        @(negedge clk);
        i_swap_req  = 1'b0;
        i_frame_end = 1'b0;
        check("swap_coincident", 32'(o_disp_page), 32'h0);
        @(negedge clk);

        // Two requests absorbed into one toggle; a later bare frame end does nothing
        pulse_swap();
        pulse_swap();
        swap_q.push_back(1'b1);
        i_frame_end = 1'b1;
        @(negedge clk);
        i_frame_end = 1'b0;
        repeat (2) @(negedge clk);
        i_frame_end = 1'b1;
        @(negedge clk);
        i_frame_end = 1'b0;
        repeat (2) @(negedge clk);
        check("swap_absorbed", 32'(o_disp_page), 32'h1);

        // Page 1 now displayed: host data written earlier is visible
        disp_read(12'h005, 12'hABC, 12'hFFA);
        host_write(13'h00A5, 12'h777, 13'h00A5, 2'b10);
        host_write(13'h10A5, 12'h888, 13'h00A5, 2'b01);

        // Read in flight across a toggle returns old-page data
        pulse_swap();
        disp_q.push_back('{pat1(1'b1, 12'h040), pat2(1'b1, 12'h040)});
        swap_q.push_back(1'b0);
        i_disp_rd_stb = 1'b1;
        i_disp_addr   = 12'h040;
        @(negedge clk);
        i_disp_rd_stb = 1'b0;
        i_frame_end   = 1'b1;
        @(negedge clk);
        i_frame_end = 1'b0;
        check("inflight_page", 32'({o_disp_page, o_disp_valid}), 32'h1);
        @(negedge clk);
        disp_read(12'h040, pat1(1'b0, 12'h040), pat2(1'b0, 12'h040));

        // Reset coinciding with a host grant: no write, no ack, outputs cleared
        i_host_req  = 1'b1;
        i_host_addr = 13'h0011;
        i_host_data = 12'h999;
        rst = 1'b1;
        @(negedge clk);
        check("rst_no_write", 32'({o_ram_we_b1, o_ram_we_b2, o_host_ack}), 32'h0);
        check("rst_mid_addr", 32'(o_ram_addr), 32'h0);
        check("rst_mid_data", 32'({o_disp_b1_data, o_disp_b2_data, o_ram_wdata}), 32'h0);
        check("rst_mid_ctl", 32'({o_disp_valid, o_swap_done, o_disp_page}), 32'h0);
        i_host_req = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        check("host_q_drained", 32'(host_q.size()), 32'h0);
        check("disp_q_drained", 32'(disp_q.size()), 32'h0);
        check("swap_q_drained", 32'(swap_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
